// File: rtl/gui_pkg.sv
// Shared colours, screen geometry defaults and draw-sequencer state encoding
// for the keyboard display pixel writers.
package gui_pkg;
    localparam int DEF_NUM_KEYS = 4;
    localparam int DEF_KEY_W    = 40;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [1:0] {
        INIT_CLEAR,
        IDLE,
        GRANT,
        DRAW
    } draw_state_t;

    function automatic logic [2:0] key_colour(input logic pressed);
        return pressed ? BLUE : WHITE;
    endfunction
endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way combinational arbiter: round-robin starting after pointer, or
// lowest-index-first when KEY_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter_4 (
    input  logic [3:0] pending,
    input  logic [1:0] pointer,
    output logic [3:0] grant,
    output logic [1:0] index
);
    logic [1:0] pick;
    logic       found;

`ifdef KEY_SCHED_FIXED_PRIO_EN
    logic unused_pointer;
    assign unused_pointer = ^pointer;

    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                pick  = 2'(i);
                found = 1'b1;
            end
        end
    end
`else
    // Walk from farthest to nearest so the key just after the pointer wins;
    // i = 4 wraps to the pointer itself, which therefore has lowest priority.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (pending[pointer + 2'(i)]) begin
                pick  = pointer + 2'(i);
                found = 1'b1;
            end
        end
    end
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_grant
        assign grant[gi] = found && (pick == 2'(gi));
    end

    assign index = pick;
endmodule

// File: rtl/key_draw_scheduler.sv
// Sequences all keyboard pixel writes: full-screen paint after reset, then
// per-key region redraws on press/release. KEY_SCHED_FIXED_PRIO_EN selects fixed-priority grants.
module key_draw_scheduler
    import gui_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEY_W    = DEF_KEY_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keys,
    input  logic       stall,
    output logic [2:0] colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam logic [7:0] KEY_LAST_COL    = 8'(KEY_W - 1);
    localparam logic [7:0] SCREEN_LAST_COL = 8'(SCREEN_W - 1);
    localparam logic [6:0] LAST_ROW        = 7'(SCREEN_H - 1);

    draw_state_t state_reg;
    logic [3:0] keys_q, pending_reg, change, clear_mask, arb_grant;
    logic [1:0] rr_ptr_reg, arb_index, key_reg;
    logic [2:0] snap_colour_reg, colour_reg, pix_colour;
    logic [7:0] px_reg, x_reg, pix_x, key_base;
    logic [6:0] py_reg, y_reg;
    logic       plot_reg, busy_reg, done_reg;
    logic       row_end, sweep_end, divider;
    logic [NUM_KEYS-1:0] col_hit;

    rr_arbiter_4 u_arb (
        .pending (pending_reg),
        .pointer (rr_ptr_reg),
        .grant   (arb_grant),
        .index   (arb_index)
    );

    // During the full-screen paint the divider falls on every key's last column.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_div
        assign col_hit[gi] = (px_reg == 8'((gi + 1) * KEY_W - 1));
    end

    always_comb begin
        change     = keys ^ keys_q;
        clear_mask = (state_reg == GRANT) ? arb_grant : 4'b0000;
        key_base   = 8'(key_reg) * 8'(KEY_W);
        if (state_reg == INIT_CLEAR) begin
            divider = |col_hit;
            row_end = (px_reg == SCREEN_LAST_COL);
            pix_x   = px_reg;
        end else begin
            divider = (px_reg == KEY_LAST_COL);
            row_end = (px_reg == KEY_LAST_COL);
            pix_x   = key_base + px_reg;
        end
        sweep_end  = row_end && (py_reg == LAST_ROW);
        pix_colour = divider ? BLACK
                   : ((state_reg == INIT_CLEAR) ? WHITE : snap_colour_reg);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= INIT_CLEAR;
            keys_q          <= 4'b0000;
            pending_reg     <= 4'b0000;
            rr_ptr_reg      <= 2'd3;
            key_reg         <= 2'd0;
            snap_colour_reg <= WHITE;
            px_reg          <= 8'd0;
            py_reg          <= 7'd0;
            colour_reg      <= BLACK;
            x_reg           <= 8'd0;
            y_reg           <= 7'd0;
            plot_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            keys_q      <= keys;
            // A fresh change on the key being granted keeps it pending.
            pending_reg <= (pending_reg & ~clear_mask) | change;
            busy_reg    <= (state_reg != IDLE);
            plot_reg    <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                INIT_CLEAR, DRAW: begin
                    if (!stall) begin
                        x_reg      <= pix_x;
                        y_reg      <= py_reg;
                        colour_reg <= pix_colour;
                        plot_reg   <= 1'b1;
                        if (row_end) begin
                            px_reg <= 8'd0;
                            if (sweep_end) begin
                                py_reg    <= 7'd0;
                                state_reg <= IDLE;
                                done_reg  <= 1'b1;
                            end else begin
                                py_reg <= py_reg + 7'd1;
                            end
                        end else begin
                            px_reg <= px_reg + 8'd1;
                        end
                    end
                end
                IDLE: begin
                    if (|pending_reg)
                        state_reg <= GRANT;
                end
                GRANT: begin
                    key_reg         <= arb_index;
                    rr_ptr_reg      <= arb_index;
                    snap_colour_reg <= key_colour(keys_q[arb_index]);
                    px_reg          <= 8'd0;
                    py_reg          <= 7'd0;
                    state_reg       <= DRAW;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign colour = colour_reg;
    assign x      = x_reg;
    assign y      = y_reg;
    assign plot   = plot_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
endmodule

// File: tb/tb_key_draw_scheduler.sv
// Directed bench for key_draw_scheduler: a queue of expected sweeps drives a
// per-pixel model checked on every falling edge.
module tb_key_draw_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keys  = 4'b0000;
    logic       stall = 1'b0;
    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot, busy, done;

    key_draw_scheduler dut (
        .clock  (clock),
        .reset  (reset),
        .keys   (keys),
        .stall  (stall),
        .colour (colour),
        .x      (x),
        .y      (y),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int base;
        int width;
        int col;
    } sweep_t;

    sweep_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int pix_n = 0;
    int plot_count = 0;
    int done_count = 0;
    int first_pix = 0;
    int last_pix = 0;
    logic stall_q = 1'b0;

    always @(posedge clock) stall_q <= stall;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_sweep(input int b, input int w, input int c);
        sweep_t s;
        s.base = b;
        s.width = w;
        s.col = c;
        exp_q.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        int i = 0;
        while (exp_q.size() != 0 && i < max_cycles) begin
            @(negedge clock);
            i++;
        end
        check(exp_q.size() == 0, {name, "_timeout"}, exp_q.size(), 0);
        tick(3);
        check(!busy && !plot, {name, "_idle"}, {busy, plot}, 0);
    endtask

    task automatic wait_pix(input string name, input int n);
        int i = 0;
        while (pix_n < n && i < 10000) begin
            @(negedge clock);
            i++;
        end
        check(pix_n >= n, {name, "_reach"}, pix_n, n);
    endtask

    // Model: pixel n of a sweep of width w sits at (base + n%w, n/w); the last
    // column of each 40-pixel key region is black, the final pixel carries done.
    initial begin
        int w, px, py, ex, ec;
        bit last;
        logic [19:0] act_v, exp_v;
        logic [7:0] prev_x;
        logic [6:0] prev_y;
        logic [2:0] prev_c;
        prev_x = '0;
        prev_y = '0;
        prev_c = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (stall_q)
                    check(!plot && x == prev_x && y == prev_y && colour == prev_c, "stall_hold",
                          {plot, x, y, colour}, {1'b0, prev_x, prev_y, prev_c});
                if (plot) begin
                    plot_count++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_plot", {x, y}, 0);
                    end else begin
                        w    = exp_q[0].width;
                        px   = pix_n % w;
                        py   = pix_n / w;
                        ex   = exp_q[0].base + px;
                        ec   = ((ex % 40) == 39) ? 0 : exp_q[0].col;
                        last = (pix_n == w * 120 - 1);
                        act_v = {x, y, colour, done, busy};
                        exp_v = {ex[7:0], py[6:0], ec[2:0], last, 1'b1};
                        check(act_v == exp_v, "pixel", act_v, exp_v);
                        if (pix_n == 0)
                            first_pix = {x, y, colour};
                        if (last) begin
                            last_pix = {x, y, colour};
                            void'(exp_q.pop_front());
                            pix_n = 0;
                        end else begin
                            pix_n++;
                        end
                    end
                end else begin
                    check(!done, "done_without_plot", done, 0);
                end
                if (done)
                    done_count++;
            end
            prev_x = x;
            prev_y = y;
            prev_c = colour;
        end
    end

    initial begin
        int base_p, base_d, lat;

        // Reset state
        #12;
        check({colour, x, y, plot, done, busy} == 0, "reset_outputs",
              {colour, x, y, plot, done, busy}, 0);

        // Full-screen paint after reset release
        push_sweep(0, 160, 7);
        base_p = plot_count;
        base_d = done_count;
        @(negedge clock);
        reset = 1'b1;
        wait_empty("init", 20000);
        check(plot_count - base_p == 19200, "init_plots", plot_count - base_p, 19200);
        check(done_count - base_d == 1, "init_done", done_count - base_d, 1);
        check(first_pix == {8'd0, 7'd0, 3'b111}, "init_first", first_pix, {8'd0, 7'd0, 3'b111});
        check(last_pix == {8'd159, 7'd119, 3'b000}, "init_last", last_pix, {8'd159, 7'd119, 3'b000});

        // Two keys in one cycle: key0 then key2
        push_sweep(0, 40, 1);
        push_sweep(80, 40, 1);
        base_p = plot_count;
        base_d = done_count;
        keys = 4'b0101;
        wait_empty("two_keys", 11000);
        check(plot_count - base_p == 9600, "two_keys_plots", plot_count - base_p, 9600);
        check(done_count - base_d == 2, "two_keys_done", done_count - base_d, 2);
        check(last_pix == {8'd119, 7'd119, 3'b000}, "key2_last", last_pix, {8'd119, 7'd119, 3'b000});

        // key0 release: latency and white redraw
        push_sweep(0, 40, 7);
        base_p = plot_count;
        keys = 4'b0100;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (plot && lat == 0)
                lat = i;
        end
        check(lat == 4, "latency", lat, 4);
        wait_empty("release", 6000);
        check(plot_count - base_p == 4800, "release_plots", plot_count - base_p, 4800);
        check(first_pix == {8'd0, 7'd0, 3'b111}, "release_first", first_pix, {8'd0, 7'd0, 3'b111});
        check(last_pix == {8'd39, 7'd119, 3'b000}, "release_last", last_pix, {8'd39, 7'd119, 3'b000});

        // key1 press with a 5-cycle stall mid-sweep
        push_sweep(40, 40, 1);
        base_p = plot_count;
        keys = 4'b0110;
        wait_pix("stall", 100);
        stall = 1'b1;
        tick(5);
        stall = 1'b0;
        wait_empty("stall", 6000);
        check(plot_count - base_p == 4800, "stall_plots", plot_count - base_p, 4800);

        // key0 toggles during its own sweep: blue finishes, white follows
        push_sweep(0, 40, 1);
        push_sweep(0, 40, 7);
        base_p = plot_count;
        base_d = done_count;
        keys = 4'b0111;
        wait_pix("toggle", 1000);
        keys = 4'b0110;
        wait_empty("toggle", 11000);
        check(plot_count - base_p == 9600, "toggle_plots", plot_count - base_p, 9600);
        check(done_count - base_d == 2, "toggle_done", done_count - base_d, 2);

        // Reset mid-sweep, then the full paint again
        push_sweep(120, 40, 1);
        keys = 4'b1110;
        wait_pix("midreset", 2000);
        #3;
        reset = 1'b0;
        keys  = 4'b0000;
        #1;
        check({colour, x, y, plot, done, busy} == 0, "midreset_outputs",
              {colour, x, y, plot, done, busy}, 0);
        exp_q.delete();
        pix_n = 0;
        tick(2);
        push_sweep(0, 160, 7);
        base_p = plot_count;
        base_d = done_count;
        reset = 1'b1;
        wait_empty("reinit", 20000);
        check(plot_count - base_p == 19200, "reinit_plots", plot_count - base_p, 19200);
        check(done_count - base_d == 1, "reinit_done", done_count - base_d, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
